// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU op encoding, default latencies and start decode (MDU_MADD_EN adds MADD-family starts)
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_t;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic mdu_is_div(mdu_op_t op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic mdu_is_start(mdu_op_t op);
`ifdef MDU_MADD_EN
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                          MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
`endif
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// mdu_arith: combinational 64-bit MDU result (mul, div, MADD-family accumulate when MDU_MADD_EN)
import mdu_pkg::*;

module mdu_arith (
    input  mdu_op_t     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res
);

    logic               w_sgn;
    logic               w_ovf;
    logic [63:0]        w_prod;
    logic [31:0]        w_d;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_q;
    logic [31:0]        w_r;

    // Sign-extend (or zero-extend) to 64 bits so one multiplier serves both flavours;
    // the divisor is forced to 1 on /0 and INT_MIN/-1 so the divider never traps.
    always_comb begin
        w_sgn  = i_op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
        w_prod = {{32{w_sgn & i_a[31]}}, i_a} * {{32{w_sgn & i_b[31]}}, i_b};
        w_ovf  = w_sgn && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
        w_d    = (i_b == 32'd0 || w_ovf) ? 32'd1 : i_b;
        w_sq   = $signed(i_a) / $signed(w_d);
        w_sr   = $signed(i_a) % $signed(w_d);
        w_q    = w_ovf ? 32'h8000_0000 : w_sgn ? w_sq : i_a / w_d;
        w_r    = w_ovf ? 32'd0 : w_sgn ? w_sr : i_a % w_d;
`ifdef MDU_MADD_EN
        o_res  = (i_op inside {MDU_MADD, MDU_MADDU}) ? {i_hi, i_lo} + w_prod :
                 (i_op inside {MDU_MSUB, MDU_MSUBU}) ? {i_hi, i_lo} - w_prod :
                 mdu_is_div(i_op) ? ((i_b == 32'd0) ? {i_hi, i_lo} : {w_r, w_q}) : w_prod;
`else
        o_res  = mdu_is_div(i_op) ? ((i_b == 32'd0) ? {i_hi, i_lo} : {w_r, w_q}) : w_prod;
`endif
    end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO with fixed-latency commit (MDU_MADD_EN enables MADD-family)
import mdu_pkg::*;

module e_mdu #(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic [31:0] E_MDUOut,
    output logic        E_Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT) + 1);

    mdu_op_t       w_op;
    logic          w_go;
    logic [63:0]   w_res;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_shi;
    logic [31:0]   r_slo;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    assign w_op     = mdu_op_t'(E_MDUOp);
    assign w_go     = E_Start & ~Req & ~E_Busy & mdu_is_start(w_op);
    assign E_Busy   = r_cnt != '0;
    assign HI       = r_hi;
    assign LO       = r_lo;

    mdu_arith u_arith (
        .i_op  (w_op),
        .i_a   (E_A),
        .i_b   (E_B),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res)
    );

    // MFHI/MFLO read the architectural registers, never the shadow copy
    always_comb begin
        E_MDUOut = (w_op == MDU_MFHI) ? r_hi : (w_op == MDU_MFLO) ? r_lo : 32'd0;
    end

    // Latch the result into the shadow at start, count down, commit on the 1->0 step;
    // anything arriving while busy (start, MTHI/MTLO, Req) leaves the in-flight op alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_shi <= '0;
            r_slo <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (E_Busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_hi <= r_shi;
                r_lo <= r_slo;
            end
        end else if (w_go) begin
            r_cnt <= mdu_is_div(w_op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
            {r_shi, r_slo} <= w_res;
        end else if (!Req) begin
            if (w_op == MDU_MTHI) r_hi <= E_A;
            if (w_op == MDU_MTLO) r_lo <= E_A;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed table-driven bench for e_mdu (expects MADDU result only when MDU_MADD_EN)
import mdu_pkg::*;

module tb_e_mdu;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          lat;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        Req = 0;
    mdu_op_t     E_MDUOp = MDU_NONE;
    logic        E_Start = 0;
    logic [31:0] E_A = 0;
    logic [31:0] E_B = 0;
    logic [31:0] E_MDUOut;
    logic        E_Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_pass = 0;
    int n_total = 0;

    e_mdu dut (
        .clk      (clk),
        .reset    (reset),
        .Req      (Req),
        .E_MDUOp  (E_MDUOp),
        .E_Start  (E_Start),
        .E_A      (E_A),
        .E_B      (E_B),
        .E_MDUOut (E_MDUOut),
        .E_Busy   (E_Busy),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input mdu_op_t op, input logic [31:0] v);
        E_MDUOp = op;
        E_A = v;
        tick();
        E_MDUOp = MDU_NONE;
    endtask

    task automatic start(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b, input logic req);
        E_MDUOp = op;
        E_A = a;
        E_B = b;
        E_Start = 1;
        Req = req;
        tick();
        E_Start = 0;
        Req = 0;
        E_MDUOp = MDU_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (E_Busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    vec_t vecs[9];
    int   n;

    initial begin
        vecs[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'h0,        32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h0,        32'h0,        5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MDU_DIVU,  32'd7,        32'd0,        32'hAAAA5555, 32'h12345678, 10, 32'hAAAA5555, 32'h12345678};
        vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1,        32'h1,        10, 32'h00000000, 32'h80000000};
        vecs[5] = '{MDU_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        10, 32'h00000002, 32'h0000000E};
        vecs[6] = '{MDU_MULT,  32'hFFFFFFFD, 32'd4,        32'h0,        32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFF4};
        vecs[7] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        10, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'h5,        32'h5,        5,  32'h00000001, 32'h00000000};

        tick();
        tick();
        reset = 0;
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);
        chk("reset_busy", {31'd0, E_Busy}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            mt(MDU_MTHI, vecs[i].pre_hi);
            mt(MDU_MTLO, vecs[i].pre_lo);
            start(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_idle(n);
            chk($sformatf("v%0d_busy", i), n, vecs[i].lat);
            chk($sformatf("v%0d_hi", i), HI, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), LO, vecs[i].exp_lo);
        end

        mt(MDU_MTHI, 32'h11111111);
        mt(MDU_MTLO, 32'h22222222);
        start(MDU_MULT, 32'd3, 32'd3, 1'b1);
        chk("req_start_busy", {31'd0, E_Busy}, 32'h0);
        Req = 1;
        mt(MDU_MTHI, 32'hBAD0BAD0);
        Req = 0;
        tick();
        chk("req_start_hi", HI, 32'h11111111);
        chk("req_start_lo", LO, 32'h22222222);

        mt(MDU_MTHI, 32'h12345678);
        E_MDUOp = MDU_MFHI;
        #1 chk("mfhi", E_MDUOut, 32'h12345678);
        E_MDUOp = MDU_MFLO;
        #1 chk("mflo", E_MDUOut, 32'h22222222);
        E_MDUOp = MDU_NONE;
        #1 chk("mdu_out_none", E_MDUOut, 32'h0);

        start(MDU_MULT, 32'd3, 32'd5, 1'b0);
        tick();
        tick();
        Req = 1;
        tick();
        Req = 0;
        wait_idle(n);
        chk("req_busy_cnt", n + 3, 5);
        chk("req_busy_hi", HI, 32'h0);
        chk("req_busy_lo", LO, 32'd15);

        start(MDU_MULTU, 32'd2, 32'd3, 1'b0);
        chk("b2b_busy", {31'd0, E_Busy}, 32'h1);
        mt(MDU_MTLO, 32'hDEADBEEF);
        chk("mtlo_busy_ignored", LO, 32'd15);
        start(MDU_MULT, 32'd100, 32'd100, 1'b0);
        E_MDUOp = MDU_MFLO;
        #1 chk("mflo_not_shadow", E_MDUOut, 32'd15);
        E_MDUOp = MDU_NONE;
        wait_idle(n);
        chk("busy_start_cnt", n + 2, 5);
        chk("busy_start_lo", LO, 32'd6);
        chk("busy_start_hi", HI, 32'd0);

        mt(MDU_MTHI, 32'h0000AAAA);
        mt(MDU_MTLO, 32'h0000BBBB);
        start(MDU_DIV, 32'd100, 32'd3, 1'b0);
        tick();
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_busy", {31'd0, E_Busy}, 32'h0);
        chk("rst_mid_hi", HI, 32'h0);
        chk("rst_mid_lo", LO, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("rst_no_late_hi", HI, 32'h0);
        chk("rst_no_late_lo", LO, 32'h0);

        mt(MDU_MTHI, 32'h0);
        mt(MDU_MTLO, 32'hFFFFFFFF);
        start(MDU_MADDU, 32'd1, 32'd1, 1'b0);
        wait_idle(n);
`ifdef MDU_MADD_EN
        chk("maddu_busy", n, 5);
        chk("maddu_hi", HI, 32'h1);
        chk("maddu_lo", LO, 32'h0);
`else
        chk("maddu_busy", n, 0);
        chk("maddu_hi", HI, 32'h0);
        chk("maddu_lo", LO, 32'hFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
